// File: rtl/sequencer_pkg.sv
// Shared constants for the sequencer front panel and loop controller:
// index ranges, step count and the button ordering inside the debounce bank.
package sequencer_pkg;

  localparam int STEPS            = 8;
  localparam int TEMPO_MAX        = 7;
  localparam int PITCH_MAX        = 15;
  localparam int TEMPO_W          = 3;
  localparam int PITCH_W          = 4;
  localparam int DEBOUNCE_DEFAULT = 1000000;  // 20 ms at 50 MHz
  localparam int CNT_W_DEFAULT    = 20;

  // Bit positions of the control buttons in the debounce bank; steps sit above.
  localparam int BTN_CLEAR    = 0;
  localparam int BTN_PITCH_DN = 1;
  localparam int BTN_PITCH_UP = 2;
  localparam int BTN_TEMPO_DN = 3;
  localparam int BTN_TEMPO_UP = 4;
  localparam int BTN_STEP_LSB = 5;
  localparam int N_BTN        = BTN_STEP_LSB + STEPS;

endpackage

// File: rtl/sequencer_pattern_editor_debounce_cell.sv
// One button input: two-flop synchroniser, hold-time debounce counter and
// a one-clock press pulse on each accepted rising level.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press
);

  logic             sync_p0;
  logic             sync_p1;
  logic             deb;
  logic             deb_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      deb_q   <= deb;
      // Any return to the accepted level restarts the hold count.
      if (sync_p1 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync_p1;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = deb;
  assign press = deb & ~deb_q;

endmodule

// File: rtl/sequencer_pattern_editor.sv
// Front-panel editor: debounces 13 buttons into an 8-step toggle pattern,
// a saturating tempo index and a saturating pitch index.
module sequencer_pattern_editor
  import sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int PITCH_RESET     = 12,
  parameter int TEMPO_RESET     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STEPS-1:0]   btn_step,
  input  logic               btn_tempo_up,
  input  logic               btn_tempo_dn,
  input  logic               btn_pitch_up,
  input  logic               btn_pitch_dn,
  input  logic               btn_clear,
  output logic [STEPS-1:0]   pattern,
  output logic [TEMPO_W-1:0] tempo_idx,
  output logic [PITCH_W-1:0] pitch_idx,
  output logic               pattern_chg
);

  function automatic logic [3:0] sat_idx(input logic [3:0] cur, input logic [3:0] max,
                                         input logic up, input logic dn);
    logic [3:0] r;
    r = cur;
    if (up && !dn && cur != max) r = cur + 4'd1;
    else if (dn && !up && cur != 4'd0) r = cur - 4'd1;
    return r;
  endfunction

  logic [N_BTN-1:0]   raw;
  logic [N_BTN-1:0]   level;
  logic [N_BTN-1:0]   press;
  logic [STEPS-1:0]   step_press;
  logic [STEPS-1:0]   pattern_nxt;
  logic [3:0]         tempo_sat;
  logic [3:0]         pitch_sat;

  assign raw = {btn_step, btn_tempo_up, btn_tempo_dn, btn_pitch_up, btn_pitch_dn, btn_clear};

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  assign step_press = press[BTN_STEP_LSB +: STEPS];

  always_comb begin
    pattern_nxt = pattern ^ step_press;
    // Clear wins over any step toggles landing on the same cycle.
    if (press[BTN_CLEAR]) pattern_nxt = '0;
    tempo_sat = sat_idx({1'b0, tempo_idx}, 4'(TEMPO_MAX),
                        press[BTN_TEMPO_UP], press[BTN_TEMPO_DN]);
    pitch_sat = sat_idx(pitch_idx, 4'(PITCH_MAX),
                        press[BTN_PITCH_UP], press[BTN_PITCH_DN]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern     <= '0;
      tempo_idx   <= TEMPO_W'(TEMPO_RESET);
      pitch_idx   <= PITCH_W'(PITCH_RESET);
      pattern_chg <= 1'b0;
    end else begin
      pattern     <= pattern_nxt;
      pattern_chg <= (pattern_nxt != pattern);
      tempo_idx   <= tempo_sat[TEMPO_W-1:0];
      pitch_idx   <= pitch_sat;
    end
  end

endmodule

// File: tb/tb_sequencer_pattern_editor.sv
// Directed bench for sequencer_pattern_editor with a short debounce window.
module tb_sequencer_pattern_editor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn_step;
  logic       btn_tempo_up, btn_tempo_dn, btn_pitch_up, btn_pitch_dn, btn_clear;
  logic [7:0] pattern;
  logic [2:0] tempo_idx;
  logic [3:0] pitch_idx;
  logic       pattern_chg;

  int n_tests = 0;
  int n_fail  = 0;
  int chg_cnt;

  localparam logic [12:0] M_CLR  = 13'h0001;
  localparam logic [12:0] M_PDN  = 13'h0002;
  localparam logic [12:0] M_PUP  = 13'h0004;
  localparam logic [12:0] M_TDN  = 13'h0008;
  localparam logic [12:0] M_TUP  = 13'h0010;

  sequencer_pattern_editor #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .PITCH_RESET    (12),
    .TEMPO_RESET    (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_step    (btn_step),
    .btn_tempo_up(btn_tempo_up),
    .btn_tempo_dn(btn_tempo_dn),
    .btn_pitch_up(btn_pitch_up),
    .btn_pitch_dn(btn_pitch_dn),
    .btn_clear   (btn_clear),
    .pattern     (pattern),
    .tempo_idx   (tempo_idx),
    .pitch_idx   (pitch_idx),
    .pattern_chg (pattern_chg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [12:0] m);
    {btn_step, btn_tempo_up, btn_tempo_dn, btn_pitch_up, btn_pitch_dn, btn_clear} = m;
  endtask

  task automatic press_btn(input logic [12:0] m);
    drive(m);
    ticks(10);
    drive(13'h0);
    ticks(10);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(13'h0);
    ticks(3);
    chk("rst_pattern", 32'(pattern), 32'h00);
    chk("rst_tempo", 32'(tempo_idx), 32'd0);
    chk("rst_pitch", 32'(pitch_idx), 32'd12);
    chk("rst_chg", 32'(pattern_chg), 32'd0);
    rst = 1'b1;
    ticks(2);

    // Step 7 press: update lands on the 7th edge after the first sampling edge.
    drive({8'h80, 5'h0});
    ticks(6);
    chk("lat_before", 32'(pattern), 32'h00);
    tick();
    chk("lat_pattern", 32'(pattern), 32'h80);
    chk("lat_chg_hi", 32'(pattern_chg), 32'd1);
    tick();
    chk("lat_chg_lo", 32'(pattern_chg), 32'd0);
    ticks(2);
    drive(13'h0);
    ticks(12);
    chk("release_nochg", 32'(pattern), 32'h80);

    // Bouncing step 0 then a long hold: one toggle only.
    chg_cnt = 0;
    drive({8'h01, 5'h0}); tick(); if (pattern_chg) chg_cnt++;
    drive(13'h0);         tick(); if (pattern_chg) chg_cnt++;
    drive({8'h01, 5'h0}); tick(); if (pattern_chg) chg_cnt++;
    drive(13'h0);         tick(); if (pattern_chg) chg_cnt++;
    drive({8'h01, 5'h0});
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pattern_chg) chg_cnt++;
    end
    chk("bounce_pattern", 32'(pattern), 32'h81);
    chk("bounce_pulses", 32'(chg_cnt), 32'd1);
    drive(13'h0);
    ticks(20);
    chk("bounce_release", 32'(pattern), 32'h81);

    // Several steps at once all toggle.
    press_btn({8'h7E, 5'h0});
    chk("multi_toggle", 32'(pattern), 32'hFF);

    // Clear beats a simultaneous step press.
    press_btn({8'h08, 5'h0} | M_CLR);
    chk("clear_wins", 32'(pattern), 32'h00);

    // Clear on an empty pattern gives no pulse.
    chg_cnt = 0;
    drive(M_CLR);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pattern_chg) chg_cnt++;
    end
    drive(13'h0);
    ticks(10);
    chk("clear_empty_pat", 32'(pattern), 32'h00);
    chk("clear_empty_chg", 32'(chg_cnt), 32'd0);

    // Saturation of both indices.
    press_btn(M_TUP);
    press_btn(M_TUP);
    chk("tempo_2", 32'(tempo_idx), 32'd2);
    for (int i = 0; i < 7; i++) press_btn(M_TUP);
    chk("tempo_sat_hi", 32'(tempo_idx), 32'd7);
    for (int i = 0; i < 5; i++) press_btn(M_PUP);
    chk("pitch_sat_hi", 32'(pitch_idx), 32'd15);
    press_btn(M_PDN);
    chk("pitch_14", 32'(pitch_idx), 32'd14);
    for (int i = 0; i < 15; i++) press_btn(M_PDN);
    chk("pitch_sat_lo", 32'(pitch_idx), 32'd0);

    // Opposing tempo presses cancel.
    for (int i = 0; i < 4; i++) press_btn(M_TDN);
    chk("tempo_3", 32'(tempo_idx), 32'd3);
    press_btn(M_TUP | M_TDN);
    chk("tempo_opposed", 32'(tempo_idx), 32'd3);
    chk("pattern_untouched", 32'(pattern), 32'h00);

    // Reset during the third debounce count discards the press.
    drive({8'h04, 5'h0});
    ticks(4);
    rst = 1'b0;
    #2;
    chk("midrst_pattern", 32'(pattern), 32'h00);
    chk("midrst_tempo", 32'(tempo_idx), 32'd0);
    chk("midrst_pitch", 32'(pitch_idx), 32'd12);
    tick();
    rst = 1'b1;
    ticks(6);
    chk("midrst_wait", 32'(pattern), 32'h00);
    tick();
    chk("midrst_toggle", 32'(pattern), 32'h04);
    chk("midrst_chg", 32'(pattern_chg), 32'd1);
    drive(13'h0);
    ticks(12);
    chk("midrst_final", 32'(pattern), 32'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
